// File: rtl/ble_rx_dma.sv
// ble_rx_dma: queues bytes from uart_rx in a small FIFO and writes each one into a
// ring region of servant_ram through a Wishbone-style master port while the CPU bus is idle.
module ble_rx_dma #(
   parameter int unsigned BITS   = 8,
   parameter int unsigned DEPTH  = 8,
   parameter logic [31:0] ADR_LL = 32'h00C0_0000,
   parameter logic [31:0] ADR_UL = 32'h00C1_0000
) (
   input  logic                     i_wb_clk,
   input  logic                     i_wb_rst_n,
   input  logic [BITS-1:0]          i_rx_dat,
   input  logic                     i_rx_done,
   input  logic                     i_cpu_cyc,
   output logic [31:0]              o_wb_adr,
   output logic [31:0]              o_wb_dat,
   output logic [3:0]               o_wb_sel,
   output logic                     o_wb_cyc,
   output logic                     o_wb_we,
   input  logic                     i_wb_ack,
   output logic                     o_grant,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_empty,
   output logic                     o_full,
   output logic                     o_overflow,
   input  logic                     i_ovf_clr
);

   localparam int unsigned AW = $clog2(DEPTH);

   if (BITS > 32 || BITS == 0) begin : g_bad_bits
      $error("ble_rx_dma: BITS must be in 1..32");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("ble_rx_dma: DEPTH must be a power of two >= 2");
   end

   typedef enum logic {
      ST_IDLE,
      ST_REQ
   } state_t;

   state_t            state_q, state_d;
   logic [BITS-1:0]   mem [DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [AW:0]       count_q;
   logic [31:0]       ring_q;
   logic              ovf_q;
   logic              empty, full, pop, push_ok, push_drop;

   assign empty     = (count_q == '0);
   assign full      = (count_q == (AW+1)'(DEPTH));
   assign pop       = (state_q == ST_REQ) && i_wb_ack;
   // A pop in the same cycle frees the slot, so a push onto a full FIFO still lands.
   assign push_ok   = i_rx_done && (!full || pop);
   assign push_drop = i_rx_done && !push_ok;

   // NOTE: the storage array is deliberately not reset; count/pointers define validity.
   always_ff @(posedge i_wb_clk) begin
      if (push_ok) mem[wr_ptr_q] <= i_rx_dat;
   end

   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
         ring_q <= ADR_LL;
      end else if (pop) begin
         ring_q <= (ring_q == ADR_UL) ? ADR_LL : ring_q + 32'd4;
      end
   end

   // Set wins over clear so a drop coinciding with a clear is never lost.
   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
         ovf_q <= 1'b0;
      end else if (push_drop) begin
         ovf_q <= 1'b1;
      end else if (i_ovf_clr) begin
         ovf_q <= 1'b0;
      end
   end

   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) state_q <= ST_IDLE;
      else             state_q <= state_d;
   end

   // NOTE: defaults first so every path assigns state_d and no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (!empty && !i_cpu_cyc) state_d = ST_REQ;
         ST_REQ:  if (i_wb_ack)             state_d = ST_IDLE;
         default:                           state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      o_wb_dat             = '0;
      o_wb_dat[BITS-1:0]   = mem[rd_ptr_q];
   end

   assign o_wb_cyc   = (state_q == ST_REQ);
   assign o_wb_we    = o_wb_cyc;
   assign o_grant    = o_wb_cyc;
   assign o_wb_sel   = {4{o_wb_cyc}};
   assign o_wb_adr   = ring_q;
   assign o_count    = count_q;
   assign o_empty    = empty;
   assign o_full     = full;
   assign o_overflow = ovf_q;

endmodule

// File: tb/tb_ble_rx_dma.sv
// Self-checking bench for ble_rx_dma: directed scenarios plus a randomized phase,
// all compared against a queue-based reference model of FIFO, ring and overflow flag.
module tb_ble_rx_dma;

   localparam int unsigned DEPTH  = 8;
   localparam logic [31:0] LL     = 32'h00C0_0000;
   localparam logic [31:0] UL     = 32'h00C1_0000;
   localparam logic [31:0] UL_W   = LL + 32'd8;
   localparam int unsigned SLOTS  = (UL - LL) / 4 + 1;
   localparam int unsigned SLOTS_W = (UL_W - LL) / 4 + 1;

   logic        clk, rst_n;
   logic        rx_done, cpu_cyc, ack, ovf_clr;
   logic [7:0]  rx_dat;
   logic [31:0] wb_adr, wb_dat;
   logic [3:0]  wb_sel, count;
   logic        wb_cyc, wb_we, grant, empty, full, overflow;

   logic        rx_done_w, cpu_w, ack_w, clr_w;
   logic [7:0]  rx_dat_w;
   logic [31:0] adr_w, dat_w;
   logic [3:0]  sel_w, count_w;
   logic        cyc_w, we_w, grant_w, empty_w, full_w, ovf_w;

   ble_rx_dma dut (
      .i_wb_clk(clk), .i_wb_rst_n(rst_n), .i_rx_dat(rx_dat), .i_rx_done(rx_done),
      .i_cpu_cyc(cpu_cyc), .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_sel(wb_sel),
      .o_wb_cyc(wb_cyc), .o_wb_we(wb_we), .i_wb_ack(ack), .o_grant(grant),
      .o_count(count), .o_empty(empty), .o_full(full), .o_overflow(overflow),
      .i_ovf_clr(ovf_clr)
   );

   ble_rx_dma #(.ADR_UL(UL_W)) dut_w (
      .i_wb_clk(clk), .i_wb_rst_n(rst_n), .i_rx_dat(rx_dat_w), .i_rx_done(rx_done_w),
      .i_cpu_cyc(cpu_w), .o_wb_adr(adr_w), .o_wb_dat(dat_w), .o_wb_sel(sel_w),
      .o_wb_cyc(cyc_w), .o_wb_we(we_w), .i_wb_ack(ack_w), .o_grant(grant_w),
      .o_count(count_w), .o_empty(empty_w), .o_full(full_w), .o_overflow(ovf_w),
      .i_ovf_clr(clr_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   // Reference model: queued bytes, number of completed writes, overflow flag.
   logic [7:0]  q [$];
   int unsigned wr_idx = 0;
   bit          ovf_m  = 1'b0;
   bit          gap    = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ring_adr(input int unsigned idx, input int unsigned slots);
      return LL + 32'(4 * (idx % slots));
   endfunction

   // One clock cycle on the main instance, called at a falling edge.
   task automatic step(input bit push, input logic [7:0] d, input bit ack_en, input bit clr);
      bit do_ack, accepted;
      check("count", 32'(count), q.size());
      check("overflow", 32'(overflow), 32'(ovf_m));
      check("empty", 32'(empty), 32'(q.size() == 0));
      check("full", 32'(full), 32'(q.size() == DEPTH));
      check("adr", wb_adr, ring_adr(wr_idx, SLOTS));
      check("sel", 32'(wb_sel), wb_cyc ? 32'hF : 32'h0);
      check("we_grant", {30'h0, wb_we, grant}, {30'h0, wb_cyc, wb_cyc});
      if (q.size() == 0 || gap) check("cyc_idle", 32'(wb_cyc), 32'h0);
      if (wb_cyc && q.size() > 0) check("dat", wb_dat, {24'h0, q[0]});
      do_ack   = ack_en && wb_cyc && (q.size() > 0);
      accepted = push && (q.size() < DEPTH || do_ack);
      ack      = do_ack;
      rx_done  = push;
      rx_dat   = d;
      ovf_clr  = clr;
      if (do_ack) begin
         void'(q.pop_front());
         wr_idx++;
      end
      if (accepted) q.push_back(d);
      if (push && !accepted) ovf_m = 1'b1;
      else if (clr)          ovf_m = 1'b0;
      gap = do_ack;
      @(negedge clk);
      ack     = 1'b0;
      rx_done = 1'b0;
      ovf_clr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned base, n;
      rst_n = 1'b1; rx_done = 0; rx_dat = 0; cpu_cyc = 0; ack = 0; ovf_clr = 0;
      rx_done_w = 0; rx_dat_w = 0; cpu_w = 0; ack_w = 0; clr_w = 0;
      #1 rst_n = 1'b0;
      #3;
      check("rst_cyc", 32'(wb_cyc), 32'h0);
      check("rst_sel", 32'(wb_sel), 32'h0);
      check("rst_adr", wb_adr, LL);
      check("rst_count", 32'(count), 32'h0);
      check("rst_empty_full", {30'h0, empty, full}, 32'h2);
      check("rst_ovf", 32'(overflow), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: single byte, exact timing
      step(1, 8'hA5, 0, 0);
      check("t1_cyc_n1", 32'(wb_cyc), 32'h0);
      check("t1_count_n1", 32'(count), 32'h1);
      step(0, 8'h00, 0, 0);
      check("t1_cyc_n2", 32'(wb_cyc), 32'h1);
      check("t1_adr", wb_adr, 32'h00C0_0000);
      check("t1_dat", wb_dat, 32'h0000_00A5);
      check("t1_sel", 32'(wb_sel), 32'hF);
      step(0, 8'h00, 1, 0);
      check("t1_cyc_after", 32'(wb_cyc), 32'h0);
      check("t1_ptr", wb_adr, 32'h00C0_0004);
      check("t1_count_after", 32'(count), 32'h0);

      // 2: CPU holds the bus, FIFO fills and overflows, then drains
      cpu_cyc = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         step(1, 8'(i), 1, 0);
         check("t2_no_write", 32'(wb_cyc), 32'h0);
      end
      check("t2_full", 32'(full), 32'h1);
      check("t2_ovf", 32'(overflow), 32'h1);
      cpu_cyc = 1'b0;
      base = wr_idx;
      for (int c = 0; c < 100 && wr_idx < base + 8; c++) step(0, 8'h00, 1, 0);
      check("t2_writes", wr_idx - base, 32'd8);
      step(0, 8'h00, 0, 1);
      check("t2_ovf_clr", 32'(overflow), 32'h0);

      // 4: push onto a full FIFO in the same cycle as an ack
      cpu_cyc = 1'b1;
      for (int i = 0; i < 8; i++) step(1, 8'($urandom), 0, 0);
      cpu_cyc = 1'b0;
      for (int c = 0; c < 10 && !wb_cyc; c++) step(0, 8'h00, 0, 0);
      check("t4_req", 32'(wb_cyc), 32'h1);
      step(1, 8'h77, 1, 0);
      check("t4_count", 32'(count), 32'd8);
      check("t4_ovf", 32'(overflow), 32'h0);
      for (int c = 0; c < 100 && q.size() > 0; c++) step(0, 8'h00, 1, 0);
      step(0, 8'h00, 0, 0);

      // 3: ring wrap on the second instance (ring of three words)
      cpu_w = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rx_done_w = 1'b1;
         rx_dat_w  = 8'hB0 + 8'(i);
         @(negedge clk);
      end
      rx_done_w = 1'b0;
      cpu_w     = 1'b0;
      n = 0;
      for (int c = 0; c < 60 && n < 4; c++) begin
         if (cyc_w) begin
            check("t3_adr", adr_w, ring_adr(n, SLOTS_W));
            check("t3_dat", dat_w, 32'h0000_00B0 + n);
            ack_w = 1'b1;
            n++;
         end
         @(negedge clk);
         ack_w = 1'b0;
      end
      check("t3_writes", n, 32'd4);
      check("t3_ptr", adr_w, ring_adr(4, SLOTS_W));
      check("t3_empty", 32'(empty_w), 32'h1);

      // 5: reset while a write is pending
      cpu_cyc = 1'b1;
      for (int i = 0; i < 3; i++) step(1, 8'hC0 + 8'(i), 0, 0);
      cpu_cyc = 1'b0;
      for (int c = 0; c < 10 && !wb_cyc; c++) step(0, 8'h00, 0, 0);
      check("t5_req", 32'(wb_cyc), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_cyc_drop", 32'(wb_cyc), 32'h0);
      check("t5_grant_drop", 32'(grant), 32'h0);
      check("t5_count", 32'(count), 32'h0);
      check("t5_ptr", wb_adr, 32'h00C0_0000);
      check("t5_empty_full", {30'h0, empty, full}, 32'h2);
      q.delete();
      wr_idx = 0;
      ovf_m  = 1'b0;
      gap    = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int c = 0; c < 6; c++) step(0, 8'h00, 1, 0);
      check("t5_no_write", 32'(wb_cyc), 32'h0);

      // Randomized traffic against the model
      for (int c = 0; c < 400; c++) begin
         cpu_cyc = ($urandom_range(3) == 0);
         step($urandom_range(9) < 4, 8'($urandom), 1'($urandom_range(1)), $urandom_range(9) == 0);
      end
      cpu_cyc = 1'b0;
      for (int c = 0; c < 200 && q.size() > 0; c++) step(0, 8'h00, 1, 0);
      check("rand_drained", q.size(), 32'h0);
      step(0, 8'h00, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ble_rx_dma.md
# ble_rx_dma

Buffers bytes from the BLE `uart_rx` receiver in a small FIFO and writes each one into a ring region of `servant_ram` through a Wishbone-style master port. It sits between `uart_rx` (upstream) and the RAM bus mux in `service` (downstream). It only starts a write when the CPU bus is idle. Received bytes are never written directly from the one-cycle `rx_done` strobe.

## Interface
Parameters:
- `BITS`, 8: received byte width; must be ≤ 32.
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `ADR_LL`, 'h00C00000: first ring address; word-aligned.
- `ADR_UL`, 'h00C10000: last ring address written before wrap; word-aligned, > `ADR_LL`.

Ports:
- `i_wb_clk`, in, 1: the single clock.
- `i_wb_rst_n`, in, 1: reset. Asynchronous, active-low.
- `i_rx_dat`, in, `BITS`: byte from `uart_rx`; valid when `i_rx_done`=1.
- `i_rx_done`, in, 1: one-cycle strobe; push `i_rx_dat`.
- `i_cpu_cyc`, in, 1: CPU memory-bus cycle active.
- `o_wb_adr`, out, 32: write address (current ring pointer).
- `o_wb_dat`, out, 32: FIFO head byte, zero-extended.
- `o_wb_sel`, out, 4: 4'b1111 while granted, else 0.
- `o_wb_cyc`, out, 1: write cycle active.
- `o_wb_we`, out, 1: equals `o_wb_cyc`.
- `i_wb_ack`, in, 1: RAM acknowledge.
- `o_grant`, out, 1: equals `o_wb_cyc`. The top-level mux selects this port and withholds ack from the CPU while it is high.
- `o_count`, out, $clog2(DEPTH)+1: FIFO occupancy.
- `o_empty`, out, 1: FIFO empty.
- `o_full`, out, 1: FIFO full.
- `o_overflow`, out, 1: sticky; a byte was dropped.
- `i_ovf_clr`, in, 1: clears `o_overflow`.

## Operation
- FIFO
  - Circular buffer with write pointer, read pointer and count.
  - Push on `i_rx_done`. Accepted if not full, or if a pop happens in the same cycle.
  - A rejected push drops the byte and sets `o_overflow`.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo `DEPTH`.
- Writer FSM has two states:
  - IDLE → REQ when `!o_empty && !i_cpu_cyc`.
  - REQ holds `o_wb_cyc`/`o_wb_we`/`o_grant` high and `o_wb_sel`=4'b1111. `o_wb_adr` = ring pointer; `o_wb_dat` = {zeros, head byte}.
  - REQ stays until `i_wb_ack`. On ack: pop the FIFO, advance the ring pointer, return to IDLE.
  - `i_cpu_cyc` rising while in REQ has no effect; the top stalls the CPU.
  - The mandatory IDLE cycle after every write gives the CPU a chance to take the bus.
- Ring pointer
  - next = (ptr == `ADR_UL`) ? `ADR_LL` : ptr + 4.
  - 32-bit arithmetic, no carry beyond bit 31.
  - `ADR_UL` itself is written, then the pointer wraps.
- Overflow flag
  - `i_ovf_clr` clears `o_overflow`.
  - Set has priority when an overflow and a clear happen in the same cycle.
- Reset (`i_wb_rst_n` low, any time, including mid-REQ):
  - Outputs drop immediately.
  - FIFO flushed; count 0.
  - Ring pointer = `ADR_LL`.
  - State IDLE.
  - `o_overflow` = 0.
  - `o_empty` = 1, `o_full` = 0.
  - All bus outputs = 0; `o_wb_adr` = `ADR_LL`.

## Timing
- All outputs come directly from registers or from state decode. There is no combinational path from `i_rx_done`, `i_cpu_cyc` or `i_wb_ack` to any output.
- Worked sequence (FIFO initially empty, bus idle, RAM acks one cycle after `cyc`):
  - Cycle N: `i_rx_done` pulses.
  - N+1: count = 1; the FSM sees non-empty and moves to REQ at the end of the cycle.
  - N+2: `o_wb_cyc` = 1.
  - N+3: ack arrives; pop and pointer advance at the end of the cycle.
  - N+4: IDLE, `o_wb_cyc` = 0.
- Sustained throughput with a 1-cycle ack: one write per 3 cycles. This far exceeds the UART byte rate.
- While `i_cpu_cyc` is held high, the FSM waits indefinitely in IDLE; pushes continue.
- `o_count`, `o_empty` and `o_full` update on the clock edge after the push or pop.

## Test plan
1. Reset, then a single byte 8'hA5 with bus idle:
   - One write: adr 'h00C00000, dat 'h000000A5, sel 4'b1111.
   - `o_wb_cyc` is high exactly two cycles after the strobe.
   - Ack → pointer becomes 'h00C00004; count returns to 0.
2. Hold `i_cpu_cyc`=1 and push 9 bytes 1..9 (`DEPTH`=8):
   - First 8 accepted; `o_full`=1; byte 9 dropped; `o_overflow`=1.
   - Release `i_cpu_cyc`: 8 writes of values 1..8 at consecutive addresses, each separated by ≥1 idle cycle.
   - Pulse `i_ovf_clr`: `o_overflow`=0.
3. Wrap, with `ADR_UL` = `ADR_LL`+8:
   - Four bytes land at +0, +4, +8, +0.
4. Push while full and acked in the same cycle:
   - Push accepted; count stays 8; `o_overflow` stays 0.
5. Assert `i_wb_rst_n`=0 mid-REQ with 3 bytes queued:
   - `o_wb_cyc` drops without waiting for a clock; count = 0; pointer = 'h00C00000.
   - After release, no write occurs until a new strobe.
